// File: rtl/i2c_pkg.sv
// Shared I2C definitions: master FSM states, per-quarter line patterns, ACK levels, default slave address.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_ACK_ADDR,
    ST_WR_DATA,
    ST_ACK_DATA,
    ST_RD_DATA,
    ST_MACK,
    ST_STOP
  } state_t;

  // Bit i of each pattern = line pulled low during quarter qi.
  localparam logic [3:0] START_SDA_LOW = 4'b1100;
  localparam logic [3:0] START_SCL_LOW = 4'b1000;
  localparam logic [3:0] STOP_SDA_LOW  = 4'b0011;
  localparam logic [3:0] STOP_SCL_LOW  = 4'b0001;
  localparam logic [3:0] SLOT_SCL_LOW  = 4'b1001;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h2A;

endpackage

// File: rtl/i2c_qtick.sv
// Quarter-SCL-period timebase: one tick every CLK_DIV clocks while enabled, held while frozen.
module i2c_qtick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic freeze,
  output logic tick
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CMAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || !en)  cnt <= '0;
    else if (!freeze) cnt <= (cnt == CMAX) ? '0 : cnt + CW'(1);
  end

  assign tick = en && !freeze && (cnt == CMAX);

endmodule

// File: rtl/i2c_master.sv
// Single-byte open-drain I2C master: START, addr+R/W, one data byte, ACK/NACK, STOP.
// Optional clock stretching when I2C_CLK_STRETCH_EN is defined.
module i2c_master
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic       rw,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  inout  wire        sda,
  inout  wire        scl
);

  state_t     state_q, state_d;
  logic [1:0] qtr;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic [7:0] wbyte;
  logic       rw_q;
  logic       tick, freeze;
  logic       sda_low, scl_low;
  logic       accept, last_q;

  assign accept = start && !busy;
  assign last_q = tick && (qtr == 2'd3);

`ifdef I2C_CLK_STRETCH_EN
  // A slave holding scl low after release stalls the timebase inside q1.
  assign freeze = (state_q != ST_IDLE) && (qtr == 2'd1) && !scl;
`else
  assign freeze = 1'b0;
`endif

  i2c_qtick #(.CLK_DIV(CLK_DIV)) u_qtick (
    .clk    (clk),
    .rst    (rst),
    .en     (busy),
    .freeze (freeze),
    .tick   (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    sda_low = 1'b0;
    scl_low = 1'b0;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_START;
      ST_START: begin
        sda_low = START_SDA_LOW[qtr];
        scl_low = START_SCL_LOW[qtr];
        if (last_q) state_d = ST_ADDR;
      end
      ST_ADDR: begin
        sda_low = ~shift[7];
        scl_low = SLOT_SCL_LOW[qtr];
        if (last_q && bit_cnt == 3'd7) state_d = ST_ACK_ADDR;
      end
      ST_ACK_ADDR: begin
        scl_low = SLOT_SCL_LOW[qtr];
        // ack_err was captured at the q1 sample of this slot
        if (last_q) state_d = ack_err ? ST_STOP : (rw_q ? ST_RD_DATA : ST_WR_DATA);
      end
      ST_WR_DATA: begin
        sda_low = ~shift[7];
        scl_low = SLOT_SCL_LOW[qtr];
        if (last_q && bit_cnt == 3'd7) state_d = ST_ACK_DATA;
      end
      ST_ACK_DATA: begin
        scl_low = SLOT_SCL_LOW[qtr];
        if (last_q) state_d = ST_STOP;
      end
      ST_RD_DATA: begin
        scl_low = SLOT_SCL_LOW[qtr];
        if (last_q && bit_cnt == 3'd7) state_d = ST_MACK;
      end
      ST_MACK: begin
        scl_low = SLOT_SCL_LOW[qtr];
        if (last_q) state_d = ST_STOP;
      end
      ST_STOP: begin
        sda_low = STOP_SDA_LOW[qtr];
        scl_low = STOP_SCL_LOW[qtr];
        if (last_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      qtr     <= 2'd0;
      bit_cnt <= 3'd0;
      shift   <= 8'h00;
      wbyte   <= 8'h00;
      rw_q    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ack_err <= 1'b0;
      rd_data <= 8'h00;
    end else begin
      done <= 1'b0;
      // busy stays up through the done cycle so a start there is ignored
      if (done) busy <= 1'b0;
      if (accept) begin
        shift   <= {addr, rw};
        wbyte   <= wr_data;
        rw_q    <= rw;
        ack_err <= 1'b0;
        busy    <= 1'b1;
        qtr     <= 2'd0;
        bit_cnt <= 3'd0;
      end else if (tick && state_q != ST_IDLE) begin
        qtr <= qtr + 2'd1;
        if (qtr == 2'd1) begin
          if ((state_q == ST_ACK_ADDR || state_q == ST_ACK_DATA) && sda == NACK) ack_err <= 1'b1;
          if (state_q == ST_RD_DATA) shift <= {shift[6:0], sda};
        end
        if (qtr == 2'd3) begin
          bit_cnt <= (state_d != state_q) ? 3'd0 : bit_cnt + 3'd1;
          if (state_q == ST_ADDR || state_q == ST_WR_DATA) shift <= {shift[6:0], 1'b0};
          if (state_q == ST_ACK_ADDR) shift <= wbyte;
          if (state_q == ST_MACK)     rd_data <= shift;
          if (state_q == ST_STOP)     done <= 1'b1;
        end
      end
    end
  end

  assign sda = sda_low ? 1'b0 : 1'bz;
  assign scl = scl_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_master.sv
// Bench for i2c_master: pulled-up bus, behavioural slave at 7'h2A, random transfers vs. a transaction-level model.
module tb_i2c_master;
  import i2c_pkg::*;

  localparam int CLK_DIV = 4;
  localparam logic [6:0] SLV = DEFAULT_SLAVE_ADDR;
  localparam int PH_IDLE = 0, PH_ADDR = 1, PH_AACK = 2, PH_WR = 3, PH_WACK = 4, PH_RD = 5, PH_RACK = 6;

  logic       clk = 1'b0;
  logic       rst, start, rw;
  logic [6:0] addr;
  logic [7:0] wr_data, rd_data;
  logic       busy, done, ack_err;
  wire        sda, scl;

  pullup (sda);
  pullup (scl);

  i2c_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst(rst), .start(start), .addr(addr), .rw(rw), .wr_data(wr_data),
    .rd_data(rd_data), .busy(busy), .done(done), .ack_err(ack_err), .sda(sda), .scl(scl)
  );

  always #5 clk = ~clk;

  // behavioural slave and bus monitor, sampling at the falling system clock
  logic       p_scl = 1'b1, p_sda = 1'b1;
  logic       slv_low = 1'b0;
  int         ph = PH_IDLE, bitc = 0, hold_cnt = 0;
  int         stretch_len = 0;
  logic [7:0] sh = 8'h00, addr_seen = 8'h00, wr_seen = 8'h00, slv_tx = 8'hCC;
  logic       m_ack = 1'b0;
  int         n_rise = 0, n_start = 0, n_stop = 0, n_done = 0;

  assign sda = slv_low ? 1'b0 : 1'bz;
  assign scl = (hold_cnt > 0) ? 1'b0 : 1'bz;

  always @(negedge clk) begin
    if (done === 1'b1) n_done <= n_done + 1;
    if (hold_cnt > 0) hold_cnt <= hold_cnt - 1;
    if (p_scl === 1'b1 && scl === 1'b1 && p_sda === 1'b1 && sda === 1'b0) begin
      n_start <= n_start + 1; ph <= PH_ADDR; bitc <= 0; sh <= 8'h00; slv_low <= 1'b0;
    end else if (p_scl === 1'b1 && scl === 1'b1 && p_sda === 1'b0 && sda === 1'b1) begin
      n_stop <= n_stop + 1; ph <= PH_IDLE; slv_low <= 1'b0;
    end else if (p_scl === 1'b0 && scl === 1'b1) begin
      n_rise <= n_rise + 1;
      if (ph == PH_ADDR || ph == PH_WR) begin sh <= {sh[6:0], sda}; bitc <= bitc + 1; end
      if (ph == PH_RACK) m_ack <= sda;
    end else if (p_scl === 1'b1 && scl === 1'b0) begin
      case (ph)
        PH_ADDR: if (bitc == 8) begin
          addr_seen <= sh;
          if (sh[7:1] == SLV) begin ph <= PH_AACK; slv_low <= 1'b1; hold_cnt <= stretch_len; end
          else ph <= PH_IDLE;
        end
        PH_AACK: begin
          bitc <= 0; sh <= 8'h00;
          if (addr_seen[0]) begin ph <= PH_RD; slv_low <= ~slv_tx[7]; end
          else begin ph <= PH_WR; slv_low <= 1'b0; end
        end
        PH_WR: if (bitc == 8) begin wr_seen <= sh; ph <= PH_WACK; slv_low <= 1'b1; end
        PH_WACK: begin slv_low <= 1'b0; ph <= PH_IDLE; end
        PH_RD: begin
          bitc <= bitc + 1;
          if (bitc == 7) begin ph <= PH_RACK; slv_low <= 1'b0; end
          else slv_low <= ~slv_tx[6-bitc];
        end
        PH_RACK: ph <= PH_IDLE;
        default: ph <= PH_IDLE;
      endcase
    end
    p_scl <= scl;
    p_sda <= sda;
  end

  int         n_chk = 0, n_pass = 0;
  logic [7:0] exp_rd = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // One transaction; the model predicts latency, flags, bus bytes and edge counts from the protocol rules.
  task automatic xfer(input logic [6:0] a, input logic r, input logic [7:0] wd,
                      input int inject_at, input int slack);
    int   lat, b_rise, b_start, b_stop, b_done, exp_lat;
    logic got, busy_at_done, ack_ok;
    ack_ok  = (a == SLV);
    exp_lat = (ack_ok ? 80 : 44) * CLK_DIV + 1;
    if (ack_ok && r) exp_rd = slv_tx;
    @(negedge clk);
    b_rise = n_rise; b_start = n_start; b_stop = n_stop; b_done = n_done;
    addr = a; rw = r; wr_data = wd; start = 1'b1;
    lat = 0; got = 1'b0; busy_at_done = 1'b0;
    while (!got && lat < 4000) begin
      @(posedge clk); #1;
      lat++;
      start = 1'b0;
      if (lat == 1) check("busy_after_start", busy, 1);
      if (done) begin got = 1'b1; busy_at_done = busy; end
      else if (inject_at != 0 && lat == inject_at) begin
        addr = ~a; rw = ~r; wr_data = ~wd; start = 1'b1;
      end
    end
    check("done_seen", got, 1);
    if (inject_at != 0) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_drop_after_done", busy, 0);
      @(posedge clk); #1;
      check("start_at_done_ignored", busy, 0);
    end
    if (slack == 0) check("latency", lat, exp_lat);
    else check("stretch_latency_in_range", (lat >= exp_lat + 50) && (lat <= exp_lat + slack), 1);
    check("busy_at_done", busy_at_done, 1);
    check("ack_err", ack_err, !ack_ok);
    check("rd_data", rd_data, exp_rd);
    repeat (8) @(posedge clk);
    #1;
    check("done_once", n_done - b_done, 1);
    check("addr_byte_on_bus", addr_seen, {a, r});
    check("scl_rises", n_rise - b_rise, ack_ok ? 19 : 10);
    check("start_cond", n_start - b_start, 1);
    check("stop_cond", n_stop - b_stop, 1);
    if (ack_ok && !r) check("slave_wr_byte", wr_seen, wd);
    if (ack_ok && r)  check("master_nack", m_ack, NACK);
  endtask

  initial begin
    int b_done;
    logic [6:0] ra;
    rst = 1'b1; start = 1'b0; addr = 7'h00; rw = 1'b0; wr_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ack_err", ack_err, 0);
    check("rst_rd_data", rd_data, 8'h00);
    check("rst_sda", sda, 1);
    check("rst_scl", scl, 1);
    @(negedge clk) rst = 1'b0;

    slv_tx = 8'hCC;
    xfer(7'h2A, 1'b0, 8'h5A, 0, 0);
    xfer(7'h2A, 1'b1, 8'h00, 0, 0);
    xfer(7'h2B, 1'b0, 8'h77, 0, 0);
    xfer(7'h2A, 1'b0, 8'h33, 50, 0);

    // reset while the address byte is on the bus (slot 3 of ADDR)
    @(negedge clk);
    b_done = n_done;
    addr = 7'h2A; rw = 1'b0; wr_data = 8'hC3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (69) @(posedge clk);
    #1;
    check("busy_before_rst", busy, 1);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_sda", sda, 1);
    check("midrst_scl", scl, 1);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    exp_rd = 8'h00;
    @(negedge clk) rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("midrst_no_done", n_done - b_done, 0);
    xfer(7'h2A, 1'b0, 8'hA5, 0, 0);

    for (int i = 0; i < 10; i++) begin
      ra = 7'($urandom);
      if (ra == SLV) ra = ra ^ 7'h01;
      slv_tx = 8'($urandom);
      xfer(($urandom_range(0, 3) == 0) ? ra : SLV, 1'($urandom), 8'($urandom), 0, 0);
    end

`ifdef I2C_CLK_STRETCH_EN
    slv_tx = 8'hCC;
    stretch_len = 100;
    xfer(7'h2A, 1'b1, 8'h00, 0, 110);
    stretch_len = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/i2c_master.md
Name: i2c_master

Overview:
- Clocked, single-byte I2C bus master that generates START, address+R/W, one data byte, ACK/NACK, and STOP on open-drain sda/scl.
- Sits directly upstream of the bus slaves and drives the same two-wire bus they listen on.
- Host side is a one-shot command interface: start pulse in, done/ack_err/rd_data out.
- Used both as the system-side bus driver and as the bench stimulus for slave blocks.

Parameters:
- CLK_DIV, 4, system clocks per quarter SCL period; legal values ≥2. SCL period = 4*CLK_DIV clocks.

Ports:
- clk  input  1  system clock; all logic on the rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle command strobe; sampled only when busy=0
- addr  input  7  target slave address, latched on an accepted start
- rw  input  1  0 = write, 1 = read; latched on an accepted start
- wr_data  input  8  byte to write; latched on an accepted start
- rd_data  output  8  byte read; valid from done until the next accepted start
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse when STOP completes
- ack_err  output  1  set with done if the address or write-data ACK was NACK; held until the next accepted start
- sda  inout  1  open-drain: drives 0 or releases to z, never drives 1
- scl  inout  1  open-drain: drives 0 or releases to z, never drives 1

Behaviour:
- Reset values: sda=z, scl=z, busy=0, done=0, ack_err=0, rd_data=0x00, FSM=IDLE, quarter counter=0.
- Reset mid-transfer releases both lines in the same cycle. There is no STOP; bus slaves recover on the next START/STOP.
- Timebase: a quarter-tick is raised every CLK_DIV clocks while busy. The FSM advances only on quarter-ticks.
- Bit slot = 4 quarters, q0..q3:
  - q0: scl low; sda updated at the start of q0.
  - q1, q2: scl released.
  - sda sampled at the end of q1.
  - q3: scl low.
- FSM states: IDLE, START, ADDR, ACK_ADDR, WR_DATA, ACK_DATA, RD_DATA, MACK, STOP.
  - IDLE: both lines released. On start with busy=0, latch {addr,rw} as the shift byte plus wr_data, clear ack_err, set busy, go to START.
  - START (4 quarters): q0–q1 sda=z, scl=z; q2 sda=0 with scl high (START condition); q3 scl=0.
  - ADDR: 8 bit slots, MSB first, shifting {addr,rw}.
  - ACK_ADDR: 1 slot, sda released.
    - Sampled 1 → set ack_err, go to STOP.
    - Sampled 0 → go to WR_DATA if rw=0, else RD_DATA.
  - WR_DATA: 8 slots, MSB first.
  - ACK_DATA: 1 slot, sda released. Sampled 1 sets ack_err. Always go to STOP.
  - RD_DATA: 8 slots, sda released, sampled bits shifted in MSB first.
  - MACK: 1 slot, master drives sda=z (NACK, single-byte read). rd_data is updated at the end of this slot.
  - STOP (4 quarters): q0 scl=0, sda=0; q1 scl=z; q2 sda=z with scl high (STOP condition); q3 idle.
    - At the end of q3: done=1 for one clock, busy=0, go to IDLE.
- Latency from the accepted start to done:
  - Full transfer: 80*CLK_DIV clocks (20 slots).
  - Address NACK: 44*CLK_DIV clocks (11 slots).
  - Both figures are +1 clock for the registered strobe.
- start while busy=1 is ignored with no side effects. start in the same cycle as done is ignored (busy is still high that cycle).
- The shift/bit counter wraps only via state change; it never counts below 0.

Optional Feature:
- I2C_CLK_STRETCH_EN
  - Defined: at q1 of every slot, if scl is still read as 0 after release, the quarter timebase freezes until scl reads 1. Latency extends by the stretch time.
  - Undefined: scl is never read back; timing is fixed as above.

Decomposition:
- Shared package i2c_pkg holds:
  - the FSM state enum;
  - constants for the START and STOP quarter sequences;
  - the ACK=0 / NACK=1 constants;
  - the default slave address 7'h2A, shared with the slave side.
- One natural sub-module, i2c_qtick: CLK_DIV counter with enable and freeze that emits the quarter-tick.

Test Plan:
- Bench bus: pull-ups on sda/scl, slave at 7'h2A returning 0xCC, CLK_DIV=4.
- Write: rst, then start with addr=0x2A, rw=0, wr_data=0x5A.
  → Bus shows START, bits 0x54, slave ACK, bits 0x5A, ACK, STOP.
  → done exactly 321 clocks after start; ack_err=0; slave captured 0x5A.
- Read: start with addr=0x2A, rw=1.
  → 0x55 on bus, master NACKs the data byte.
  → rd_data=0xCC at done; ack_err=0.
- Wrong address: start with addr=0x2B, rw=0.
  → No ACK, STOP issued after the ACK slot.
  → done at 177 clocks; ack_err=1; no data slots on the bus.
- Busy rejection: second start pulse 50 clocks into a transfer.
  → Ignored: exactly one done, latched operands unchanged.
- Reset mid-transfer: assert rst during the ADDR slot 3.
  → sda=z and scl=z on the next clock; busy=0; no done.
  → The following write to 0x2A completes normally.
- With I2C_CLK_STRETCH_EN: bench holds scl low for 100 clocks in ACK_ADDR.
  → done delayed by about 100 clocks; rd_data/ack_err unchanged versus the unstretched run.
